// File: rtl/mock_spi_pkg.sv
// Shared constants for the mock SPI sensor slice.
// FSM encodings, command bit values, CTRL/STATUS bit layout.
package mock_spi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_TX   = 2'd2;
  localparam logic [1:0] ST_RX   = 2'd3;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  localparam int CTRL_INT_EN   = 0;
  localparam int CTRL_HOLD     = 1;
  localparam int CTRL_STEP_LSB = 4;

  localparam logic [7:0] CTRL_RST   = 8'h11;
  localparam logic [7:0] CTRL_WMASK = 8'hF3;

  localparam int STAT_PEND = 0;
  localparam int STAT_OVR  = 1;

endpackage

// File: rtl/mock_spi_sensor_if.sv
// SPI pin bundle between a master and the mock sensor.
// Ports: spi_clk (idle high), spi_cs_n, spi_mosi, spi_miso.
interface mock_spi_sensor_if;

  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );

endinterface

// File: rtl/spi_input_sync.sv
// 2-flop synchroniser + edge detect for SPI pins.
// In: sys_clk, reset, spi_clk/cs_n/mosi. Out: levels, edges.
module spi_input_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic cs_lvl,
  output logic mosi_lvl,
  output logic clk_rise,
  output logic clk_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [2:0] s1;
  logic [2:0] s2;
  logic [1:0] s3;
  logic [2:0] warm;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1   <= 3'b011;
      s2   <= 3'b011;
      s3   <= 2'b11;
      warm <= '0;
    end else begin
      s1   <= {spi_mosi, spi_cs_n, spi_clk};
      s2   <= s1;
      s3   <= s2[1:0];
      warm <= {warm[1:0], 1'b1};
    end
  end

  // Edges stay masked until the pipe holds real pin
  // values, so a bus held low across reset is ignored.
  assign cs_lvl   = s2[1];
  assign mosi_lvl = s2[2];
  assign clk_rise = warm[2] &  s2[0] & ~s3[0];
  assign clk_fall = warm[2] & ~s2[0] &  s3[0];
  assign cs_rise  = warm[2] &  s2[1] & ~s3[1];
  assign cs_fall  = warm[2] & ~s2[1] &  s3[1];

endmodule

// File: rtl/mock_spi_sensor.sv
// Parametrised virtual SPI sensor (mode 3 slave, burst R/W).
// Ports: sys_clk, reset, sample_trigger, spi (slave), irq.
module mock_spi_sensor
  import mock_spi_pkg::*;
#(
  parameter int         N_CH        = 6,
  parameter int         CH_WIDTH    = 16,
  parameter logic [6:0] BASE_ADDR   = 7'h3B,
  parameter logic [6:0] CTRL_ADDR   = 7'h6B,
  parameter logic [6:0] STATUS_ADDR = 7'h3A,
  parameter logic [6:0] WHOAMI_ADDR = 7'h75,
  parameter logic [7:0] WHOAMI_VAL  = 8'h68,
  parameter int         INT_TIMEOUT = 50000
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sample_trigger,
  mock_spi_sensor_if.slave spi,
  output logic             irq
);

  localparam int BYTES = CH_WIDTH / 8;
  localparam int CH_LO = int'(BASE_ADDR);
  localparam int CH_HI = CH_LO + N_CH * BYTES;
  localparam int TW =
    (INT_TIMEOUT < 2) ? 1 : $clog2(INT_TIMEOUT + 1);

  localparam logic MAP_CLASH =
    (int'(CTRL_ADDR) >= CH_LO &&
     int'(CTRL_ADDR) < CH_HI) ||
    (int'(STATUS_ADDR) >= CH_LO &&
     int'(STATUS_ADDR) < CH_HI) ||
    (int'(WHOAMI_ADDR) >= CH_LO &&
     int'(WHOAMI_ADDR) < CH_HI);

  if (MAP_CLASH || (CH_WIDTH % 8) != 0) begin : g_bad_map
    $error("mock_spi_sensor: bad register map parameters");
  end

  logic cs_lvl, mosi_lvl;
  logic clk_rise, clk_fall;
  logic cs_rise, cs_fall;

  logic [7:0]          ctrl;
  logic [CH_WIDTH-1:0] seq;
  logic [CH_WIDTH-1:0] seq_n;
  logic [CH_WIDTH-1:0] ch [N_CH];
  logic                pending;
  logic                overrun;
  logic [TW-1:0]       timer;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] tx_byte;
  logic [6:0] addr;
  logic       miso;

  logic [7:0] cmd_byte;
  logic [7:0] lk_byte;
  logic [7:0] stat_byte;
  logic [6:0] lk_addr;
  logic       in_rng;
  logic       int_en, hold, trig_ok, do_upd;
  logic       act, is_rd, cmd_done, tx_next, rx_done;
  logic       load, rd_status, rd_clr, ctrl_wr;

  spi_input_sync u_sync (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .spi_clk  (spi.spi_clk),
    .spi_cs_n (spi.spi_cs_n),
    .spi_mosi (spi.spi_mosi),
    .cs_lvl   (cs_lvl),
    .mosi_lvl (mosi_lvl),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  assign spi.spi_miso = miso;

  assign int_en  = ctrl[CTRL_INT_EN];
  assign hold    = ctrl[CTRL_HOLD];
  assign trig_ok = sample_trigger && !hold;
  // Updates only land while the bus is idle, which is
  // what keeps a burst snapshot coherent.
  assign do_upd  = cs_lvl && (pending || trig_ok);
  assign seq_n   =
    seq + CH_WIDTH'(ctrl[CTRL_STEP_LSB +: 4]);

  // A cs_n rise overrides any same-cycle bit event.
  assign act      = !cs_rise;
  assign cmd_byte = {shreg[6:0], mosi_lvl};
  assign is_rd    = cmd_byte[7] == CMD_READ;
  assign cmd_done = act && state == ST_CMD &&
                    clk_rise && bit_cnt == 3'd7;
  assign tx_next  = act && state == ST_TX &&
                    clk_fall && bit_cnt == 3'd7;
  assign rx_done  = act && state == ST_RX &&
                    clk_rise && bit_cnt == 3'd7;

  assign lk_addr   = (state == ST_CMD) ?
                     cmd_byte[6:0] : addr + 7'd1;
  assign load      = (cmd_done && is_rd) || tx_next;
  assign rd_status = load && lk_addr == STATUS_ADDR;
  assign rd_clr    = cmd_done && is_rd && in_rng;
  assign ctrl_wr   = rx_done && addr == CTRL_ADDR;

  always_comb begin
    stat_byte = '0;
    stat_byte[STAT_PEND] = pending;
    stat_byte[STAT_OVR]  = overrun;
    lk_byte = '0;
    in_rng  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      for (int j = 0; j < BYTES; j++) begin
        if (int'(lk_addr) == CH_LO + i * BYTES + j) begin
          lk_byte = ch[i][CH_WIDTH-1-8*j -: 8];
          in_rng  = 1'b1;
        end
      end
    end
    unique case (1'b1)
      (lk_addr == CTRL_ADDR):   lk_byte = ctrl;
      (lk_addr == STATUS_ADDR): lk_byte = stat_byte;
      (lk_addr == WHOAMI_ADDR): lk_byte = WHOAMI_VAL;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ctrl    <= CTRL_RST;
      seq     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      irq     <= 1'b0;
      timer   <= '0;
      for (int i = 0; i < N_CH; i++) ch[i] <= '0;
    end else begin
      if (ctrl_wr) ctrl <= cmd_byte & CTRL_WMASK;

      if (do_upd) begin
        seq <= seq_n;
        for (int i = 0; i < N_CH; i++)
          ch[i] <= seq_n + CH_WIDTH'(i);
      end

      if (do_upd) pending <= 1'b0;
      else if (trig_ok && !cs_lvl) pending <= 1'b1;

      if (trig_ok && pending) overrun <= 1'b1;
      else if (rd_status) overrun <= 1'b0;

      if (do_upd) begin
        irq   <= int_en;
        timer <= TW'(INT_TIMEOUT);
      end else if (ctrl_wr && !cmd_byte[CTRL_INT_EN]) begin
        irq <= 1'b0;
      end else if (rd_clr) begin
        irq <= 1'b0;
      end else if (irq) begin
        if (timer <= TW'(1)) irq <= 1'b0;
        if (timer != '0) timer <= timer - TW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      addr    <= '0;
      tx_byte <= '0;
      miso    <= 1'b0;
    end else if (cs_rise) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      miso    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD: begin
          if (clk_rise) begin
            shreg   <= cmd_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (cmd_done) begin
              addr    <= lk_addr;
              tx_byte <= lk_byte;
              state   <= (cmd_byte[7] == CMD_WRITE) ?
                         ST_RX : ST_TX;
            end
          end
        end
        ST_TX: begin
          if (clk_fall) begin
            miso    <= tx_byte[3'd7 - bit_cnt];
            bit_cnt <= bit_cnt + 3'd1;
            if (tx_next) begin
              addr    <= lk_addr;
              tx_byte <= lk_byte;
            end
          end
        end
        ST_RX: begin
          if (clk_rise) begin
            shreg   <= cmd_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (rx_done) addr <= addr + 7'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
